// File: rtl/maxpool_seq_ctrl_if.sv
// Bus bundle of the pooling engine: scheduler handshake, input-buffer read port
// and output-buffer write port.
interface maxpool_seq_ctrl_if #(
  parameter int unsigned BITWIDTH = 32,
  parameter int unsigned ADDR_W   = 12
);
  logic                start;
  logic                busy;
  logic                done;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;
  logic [BITWIDTH-1:0] rd_data;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [BITWIDTH-1:0] wr_data;
  logic                wr_ready;

  modport master (
    input  start, rd_data, wr_ready,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, rd_data, wr_ready,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/maxpool_seq_ctrl.sv
// Sequential 2x2 / stride-2 signed max-pooling controller: four reads per window,
// running signed max, one write per window into the pooled buffer.
module maxpool_seq_ctrl #(
  parameter int unsigned BITWIDTH = 32,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned IN_DIM   = 28,
  parameter int unsigned ADDR_W   = 12
) (
  input logic                clk,
  input logic                rst_n,
  maxpool_seq_ctrl_if.master bus
);
  localparam int unsigned OUT_DIM  = IN_DIM / 2;
  localparam int unsigned IN_AREA  = IN_DIM * IN_DIM;
  localparam int unsigned OUT_AREA = OUT_DIM * OUT_DIM;
  localparam int unsigned C_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned P_W      = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, WRITE, DONE} state_t;

  state_t                     state, state_n;
  logic [C_W-1:0]             c, c_n;
  logic [P_W-1:0]             i, i_n, j, j_n;
  logic [1:0]                 k, k_n;
  logic signed [BITWIDTH-1:0] acc, acc_n, datum, fold;
  logic                       busy_n, done_n, rd_en_n, wr_en_n;
  logic [ADDR_W-1:0]          rd_addr_n, wr_addr_n;
  logic [BITWIDTH-1:0]        wr_data_n;
  logic                       last_win;

  // Input word k of window (row, col): k[1] picks the lower row, k[0] the right column.
  function automatic logic [ADDR_W-1:0] rd_addr_of(input logic [C_W-1:0] ch,
                                                   input logic [P_W-1:0] row,
                                                   input logic [P_W-1:0] col,
                                                   input logic [1:0]     kk);
    return ADDR_W'(32'(ch) * IN_AREA + (2 * 32'(row) + 32'(kk[1])) * IN_DIM
                   + 2 * 32'(col) + 32'(kk[0]));
  endfunction

  function automatic logic [ADDR_W-1:0] wr_addr_of(input logic [C_W-1:0] ch,
                                                   input logic [P_W-1:0] row,
                                                   input logic [P_W-1:0] col);
    return ADDR_W'(32'(ch) * OUT_AREA + 32'(row) * OUT_DIM + 32'(col));
  endfunction

  assign datum    = $signed(bus.rd_data);
  assign fold     = (datum > acc) ? datum : acc;
  assign last_win = (c == C_W'(CHANNELS - 1)) && (i == P_W'(OUT_DIM - 1))
                    && (j == P_W'(OUT_DIM - 1));

  // Next state and next values of every registered output.
  always_comb begin
    state_n   = state;
    c_n       = c;
    i_n       = i;
    j_n       = j;
    k_n       = k;
    acc_n     = acc;
    busy_n    = bus.busy;
    done_n    = 1'b0;
    rd_en_n   = 1'b0;
    rd_addr_n = bus.rd_addr;
    wr_en_n   = bus.wr_en;
    wr_addr_n = bus.wr_addr;
    wr_data_n = bus.wr_data;

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_n   = FETCH;
          c_n       = '0;
          i_n       = '0;
          j_n       = '0;
          k_n       = '0;
          busy_n    = 1'b1;
          rd_en_n   = 1'b1;
          rd_addr_n = '0;
        end
      end

      FETCH: begin
        // Datum of fetch k-1 is on rd_data now; the first one loads acc outright.
        if (k == 2'd1) begin
          acc_n = datum;
        end else if (k != 2'd0) begin
          acc_n = fold;
        end
        if (k == 2'd3) begin
          state_n = CAPTURE;
          k_n     = '0;
        end else begin
          k_n       = k + 2'd1;
          rd_en_n   = 1'b1;
          rd_addr_n = rd_addr_of(c, i, j, k + 2'd1);
        end
      end

      CAPTURE: begin
        state_n   = WRITE;
        wr_en_n   = 1'b1;
        wr_addr_n = wr_addr_of(c, i, j);
        wr_data_n = fold;
      end

      WRITE: begin
        if (bus.wr_ready) begin
          wr_en_n = 1'b0;
          if (last_win) begin
            state_n = DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            if (j == P_W'(OUT_DIM - 1)) begin
              j_n = '0;
              if (i == P_W'(OUT_DIM - 1)) begin
                i_n = '0;
                c_n = c + 1'b1;
              end else begin
                i_n = i + 1'b1;
              end
            end else begin
              j_n = j + 1'b1;
            end
            state_n   = FETCH;
            rd_en_n   = 1'b1;
            rd_addr_n = rd_addr_of(c_n, i_n, j_n, 2'd0);
          end
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      c           <= '0;
      i           <= '0;
      j           <= '0;
      k           <= '0;
      acc         <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.rd_en   <= 1'b0;
      bus.rd_addr <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
    end else begin
      state       <= state_n;
      c           <= c_n;
      i           <= i_n;
      j           <= j_n;
      k           <= k_n;
      acc         <= acc_n;
      bus.busy    <= busy_n;
      bus.done    <= done_n;
      bus.rd_en   <= rd_en_n;
      bus.rd_addr <= rd_addr_n;
      bus.wr_en   <= wr_en_n;
      bus.wr_addr <= wr_addr_n;
      bus.wr_data <= wr_data_n;
    end
  end
endmodule

// File: tb/tb_maxpool_seq_ctrl.sv
// Bench for maxpool_seq_ctrl: a full-size instance for timing/stall/reset sequences
// and a 4x4 single-channel instance for vector tables and random windows.
module tb_maxpool_seq_ctrl;
  localparam int unsigned BW   = 32;
  localparam int unsigned AW   = 12;
  localparam int unsigned CH_A = 2;
  localparam int unsigned IN_A = 28;
  localparam int unsigned NW_A = CH_A * (IN_A / 2) * (IN_A / 2);
  localparam int unsigned IN_B = 4;
  localparam int unsigned NW_B = 4;

  typedef struct packed {
    logic [3:0][BW-1:0] d;
    logic [BW-1:0]      expv;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  logic [BW-1:0] mem_a [4096];
  logic [BW-1:0] mem_b [16];
  logic [BW-1:0] exp_a [NW_A];
  vec_t          vecs  [8];
  logic [AW-1:0] b_rd [$];
  logic [AW-1:0] b_wa [$];
  logic [BW-1:0] b_wd [$];
  int            b_done;

  maxpool_seq_ctrl_if #(.BITWIDTH(BW), .ADDR_W(AW)) ia ();
  maxpool_seq_ctrl_if #(.BITWIDTH(BW), .ADDR_W(AW)) ib ();

  maxpool_seq_ctrl #(.BITWIDTH(BW), .CHANNELS(CH_A), .IN_DIM(IN_A), .ADDR_W(AW)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia));
  maxpool_seq_ctrl #(.BITWIDTH(BW), .CHANNELS(1), .IN_DIM(IN_B), .ADDR_W(AW)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Buffers with one-cycle read latency; garbage when not read.
  always @(posedge clk) begin
    ia.rd_data <= ia.rd_en ? mem_a[ia.rd_addr] : $urandom();
    ib.rd_data <= ib.rd_en ? mem_b[ib.rd_addr[3:0]] : $urandom();
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic vec_t mkv(input int a, input int b, input int c, input int d, input int e);
    vec_t v;
    v.d[0] = 32'(a); v.d[1] = 32'(b); v.d[2] = 32'(c); v.d[3] = 32'(d);
    v.expv = 32'(e);
    return v;
  endfunction

  // Reference: signed max over the 2x2 window whose top-left input word is at base.
  function automatic logic [BW-1:0] win_max(input bit on_a, input int base, input int in_dim);
    logic signed [BW-1:0] m, v;
    m = '0;
    for (int q = 0; q < 4; q++) begin
      int a;
      a = base + (q / 2) * in_dim + (q % 2);
      v = on_a ? mem_a[a] : mem_b[a];
      if (q == 0 || v > m) m = v;
    end
    return m;
  endfunction

  task automatic build_exp_a();
    for (int c = 0; c < CH_A; c++)
      for (int i = 0; i < IN_A / 2; i++)
        for (int j = 0; j < IN_A / 2; j++)
          exp_a[c * 196 + i * 14 + j] = win_max(1'b1, c * 784 + 2 * i * IN_A + 2 * j, IN_A);
  endtask

  // One pass of the full-size instance, started in the current (cycle 0) cycle.
  task automatic pass_a(input int stall_win, input int stall_n, input int rst_win,
                        input bit hold_start, input int glitch);
    int nw, done_cnt, stall_left, exp_done, limit;
    bit stalled, was_reset;
    logic [AW-1:0] h_addr;
    logic [BW-1:0] h_data;
    nw = 0; done_cnt = 0; stall_left = stall_n; stalled = 0; was_reset = 0;
    h_addr = '0; h_data = '0;
    exp_done = 6 * NW_A + 1 + stall_n;
    limit = (rst_win >= 0) ? 6 * (rst_win + 2) : exp_done + (hold_start ? 2 : 3);
    ia.start = 1'b1;
    ia.wr_ready = 1'b1;
    for (int rel = 1; rel <= limit; rel++) begin
      @(negedge clk);
      if (!hold_start)
        ia.start = (glitch > 0) && (rel == glitch || rel == exp_done);
      if (was_reset) begin
        check("quiet_after_reset", {ia.busy, ia.done, ia.rd_en, ia.wr_en}, 0);
        continue;
      end
      if (rel == 1)
        check("first_fetch", {ia.busy, ia.rd_en, ia.rd_addr}, {1'b1, 1'b1, 12'h0});
      if (stalled)
        check("stall_hold", {ia.wr_en, ia.rd_en, ia.wr_addr, ia.wr_data},
              {1'b1, 1'b0, h_addr, h_data});
      if (ia.wr_en) begin
        if (nw == stall_win && stall_left > 0) begin
          ia.wr_ready = 1'b0;
          stall_left--;
          stalled = 1'b1;
          h_addr = ia.wr_addr;
          h_data = ia.wr_data;
        end else begin
          ia.wr_ready = 1'b1;
          stalled = 1'b0;
          if (nw == 0) check("first_wr_cycle", 64'(rel), 64'd6);
          check("wr_in_range", 64'(nw < NW_A), 64'd1);
          check("wr_addr", 64'(ia.wr_addr), 64'(nw));
          check("wr_data", 64'(ia.wr_data), 64'(exp_a[nw % NW_A]));
          nw++;
        end
      end
      if (ia.done) begin
        done_cnt++;
        check("done_cycle", 64'(rel), 64'(exp_done));
        check("busy_at_done", 64'(ia.busy), 64'd0);
      end
      if (hold_start && rel == exp_done + 1)
        check("idle_after_done", {ia.busy, ia.done, ia.rd_en}, 0);
      if (hold_start && rel == exp_done + 2)
        check("restart_fetch", {ia.busy, ia.rd_en, ia.rd_addr}, {1'b1, 1'b1, 12'h0});
      if (!hold_start && rst_win < 0 && rel > exp_done)
        check("idle_after_pass", {ia.busy, ia.done, ia.rd_en, ia.wr_en}, 0);
      if (rst_win >= 0 && nw == rst_win && ia.rd_en) begin
        rst_n = 1'b0;
        was_reset = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        check("reset_outputs", {ia.busy, ia.done, ia.rd_en, ia.rd_addr, ia.wr_en,
                                ia.wr_addr, ia.wr_data}, 0);
      end
    end
    if (rst_win >= 0) begin
      check("reset_taken", 64'(was_reset), 64'd1);
      check("done_count_reset", 64'(done_cnt), 64'd0);
      check("write_count_reset", 64'(nw), 64'(rst_win));
    end else begin
      check("done_count", 64'(done_cnt), 64'd1);
      check("write_count", 64'(nw), 64'(NW_A));
    end
    ia.start = 1'b0;
    ia.wr_ready = 1'b1;
    if (hold_start) begin
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("abort_second_pass", {ia.busy, ia.rd_en, ia.wr_en}, 0);
    end
  endtask

  // One pass of the 4x4 instance, collecting reads and accepted writes.
  task automatic pass_b(input bit rnd_ready);
    b_rd.delete(); b_wa.delete(); b_wd.delete();
    b_done = 0;
    ib.start = 1'b1;
    for (int t = 0; t < 200 && b_done == 0; t++) begin
      @(negedge clk);
      ib.start = 1'b0;
      if (ib.rd_en) b_rd.push_back(ib.rd_addr);
      ib.wr_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ib.wr_en && ib.wr_ready) begin
        b_wa.push_back(ib.wr_addr);
        b_wd.push_back(ib.wr_data);
      end
      if (ib.done) b_done++;
    end
    check("b_done", 64'(b_done), 64'd1);
    check("b_write_count", 64'(b_wa.size()), 64'(NW_B));
    ib.wr_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int exp_rd [16];
    int offs [4];
    logic [BW-1:0] exp_b [NW_B];
    exp_rd = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
    offs   = '{0, 1, 4, 5};
    vecs[0] = mkv(-5, -3, -8, -1, -1);
    vecs[1] = mkv(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    vecs[2] = mkv(7, 1, 2, 3, 7);
    vecs[3] = mkv(1, 7, 2, 3, 7);
    vecs[4] = mkv(1, 2, 7, 3, 7);
    vecs[5] = mkv(1, 2, 3, 7, 7);
    vecs[6] = mkv(32'h7FFF_FFFF, -1, 32'h8000_0000, 5, 32'h7FFF_FFFF);
    vecs[7] = mkv(-7, -7, -9, -7, -7);

    rst_n = 1'b0;
    ia.start = 1'b0; ia.wr_ready = 1'b1;
    ib.start = 1'b0; ib.wr_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_a", {ia.busy, ia.done, ia.rd_en, ia.rd_addr, ia.wr_en, ia.wr_addr, ia.wr_data}, 0);
    check("reset_b", {ib.busy, ib.done, ib.rd_en, ib.rd_addr, ib.wr_en, ib.wr_addr, ib.wr_data}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Vector table on the 4x4 instance, four windows per pass.
    for (int p = 0; p < 2; p++) begin
      for (int w = 0; w < 4; w++)
        for (int q = 0; q < 4; q++)
          mem_b[8 * (w / 2) + 2 * (w % 2) + offs[q]] = vecs[4 * p + w].d[q];
      pass_b(1'b0);
      if (p == 0) begin
        check("b_read_count", 64'(b_rd.size()), 64'd16);
        for (int r = 0; r < 16 && r < b_rd.size(); r++)
          check("b_rd_addr", 64'(b_rd[r]), 64'(exp_rd[r]));
      end
      for (int w = 0; w < NW_B && w < b_wa.size(); w++) begin
        check("b_wr_addr", 64'(b_wa[w]), 64'(w));
        check("b_vec_data", 64'(b_wd[w]), 64'(vecs[4 * p + w].expv));
      end
    end

    // Random windows with random write back-pressure.
    for (int it = 0; it < 8; it++) begin
      for (int a = 0; a < 16; a++)
        mem_b[a] = (it % 2 == 0) ? 32'($urandom()) : 32'($urandom_range(0, 4)) - 32'd2;
      for (int w = 0; w < NW_B; w++)
        exp_b[w] = win_max(1'b0, 8 * (w / 2) + 2 * (w % 2), IN_B);
      pass_b(1'b1);
      for (int w = 0; w < NW_B && w < b_wa.size(); w++) begin
        check("b_rand_addr", 64'(b_wa[w]), 64'(w));
        check("b_rand_data", 64'(b_wd[w]), 64'(exp_b[w]));
      end
    end

    // Full-size pass over mem[a] = a.
    for (int a = 0; a < 4096; a++) mem_a[a] = 32'(a);
    build_exp_a();
    pass_a(-1, 0, -1, 1'b0, 0);

    // Random data, 3-cycle stall on window 5, start pulses while busy and in DONE.
    for (int a = 0; a < 4096; a++) mem_a[a] = 32'($urandom());
    build_exp_a();
    pass_a(5, 3, -1, 1'b0, 50);

    // start held through DONE restarts immediately; that pass is then reset away.
    pass_a(-1, 0, -1, 1'b1, 0);

    // Reset during window 10 fetch.
    pass_a(-1, 0, 10, 1'b0, 0);

    // Fresh pass after the abort starts from address 0.
    for (int a = 0; a < 4096; a++) mem_a[a] = 32'($urandom());
    build_exp_a();
    pass_a(-1, 0, -1, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/maxpool_seq_ctrl.md
# maxpool_seq_ctrl

Sequential 2×2/stride-2 max-pooling engine and controller for the LeNet accelerator's pooling stage. On a `start` pulse it walks every pooling window of a CHANNELS×IN_DIM×IN_DIM signed feature map held in an on-chip buffer. For each window it issues four reads, reduces them to a signed maximum, and writes one result into the pooled output buffer (CHANNELS×IN_DIM/2×IN_DIM/2). It sits between the conv-1 output buffer and the conv-2 input buffer, and is started by the layer scheduler.

## Interface
- BITWIDTH, 32, signed data word width
- CHANNELS, 2, number of feature-map channels
- IN_DIM, 28, input rows/cols; must be even; OUT_DIM = IN_DIM/2
- ADDR_W, 12, address width of both buffers; must hold CHANNELS·IN_DIM²

Ports (single clock domain):
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  begin one full pooling pass; sampled only in IDLE
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last write is accepted
- rd_en  out  1  input-buffer read strobe
- rd_addr  out  ADDR_W  input-buffer address; c·IN_DIM² + r·IN_DIM + col
- rd_data  in  BITWIDTH  signed read data; valid exactly 1 cycle after rd_en
- wr_en  out  1  output-buffer write request
- wr_addr  out  ADDR_W  output address; c·OUT_DIM² + i·OUT_DIM + j
- wr_data  out  BITWIDTH  signed pooled value
- wr_ready  in  1  output buffer accepts the write when wr_en && wr_ready

## Operation
- All outputs are registered.
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, wr_en=0, wr_addr=0, wr_data=0. The FSM resets to IDLE and all counters to 0.
- Counters: channel c in 0..CHANNELS-1, row i and column j in 0..OUT_DIM-1, fetch index k in 0..3.
- Traversal order: j fastest, then i, then c. The output address increments by 1 per window.
- FSM:
  - IDLE: when start=1, clear counters and go to FETCH.
  - FETCH (4 cycles, k=0..3): rd_en=1. rd_addr selects, in order, (2i,2j), (2i,2j+1), (2i+1,2j), (2i+1,2j+1) of channel c. After k=3, go to CAPTURE.
  - CAPTURE (1 cycle): rd_en=0. Computes the final max from acc and the 4th datum, then loads wr_data, wr_addr and wr_en=1. Go to WRITE.
  - WRITE: hold wr_en, wr_addr and wr_data stable until wr_ready=1.
    - On acceptance, if this was the last window, go to DONE.
    - Otherwise advance (j, i, c) with wrap-around, drop wr_en, and go to FETCH.
  - DONE (1 cycle): done=1, busy=0, then go to IDLE.
- Accumulator loading:
  - The datum returning in the cycle after k=0 loads acc directly; the reset value is never used in a comparison.
  - Each subsequent datum updates acc = max(acc, rd_data) using a signed compare.
  - The 4th datum, returning in CAPTURE, is folded combinationally into wr_data.
- Ties: any equal value is correct, because the result is value-identical.
- rd_addr holds its last value while rd_en=0.
- start is ignored outside IDLE, including in DONE. If start is still high in the IDLE cycle after DONE, a new pass begins.
- rst_n=0 mid-pass: the next edge forces the reset values. The pass is abandoned with no done pulse and no further writes, and any pending write is dropped.
- No arithmetic widening: the pooling result is one of the inputs, so it is exactly BITWIDTH bits.

## Timing
- Cycle 0: IDLE samples start=1.
- Cycles 1–4: FETCH. busy goes high in cycle 1.
- Cycle 5: CAPTURE.
- Cycle 6: first wr_en.
- Minimum cost is 6 cycles per window: 4 FETCH, 1 CAPTURE, 1 WRITE when wr_ready=1.
- Each cycle of wr_ready=0 in WRITE adds one cycle; no reads are issued while stalled.
- The next window's first rd_en comes in the cycle after write acceptance.
- Defaults with wr_ready tied to 1: 392 windows. The last write is in cycle 2352; done=1 and busy=0 in cycle 2353; the block is back in IDLE at cycle 2354.

## Test plan
- Default params, mem[a]=a for a<1568, wr_ready=1 → 392 writes to wr_addr 0..391. wr_data[i·14+j] = c·784 + (2i+1)·28 + 2j+1. done pulses only in cycle 2353.
- IN_DIM=4, CHANNELS=1:
  - rd_addr sequence is 0,1,4,5 then 2,3,6,7 then 8,9,12,13 then 10,11,14,15.
  - wr_addr is 0..3.
  - A window of {-5,-3,-8,-1} gives -1; an all-0x80000000 window gives 0x80000000.
- Max in each position: place the maximum at k=0, 1, 2, 3 in successive windows (e.g. 7 among {1,2,3}) → wr_data=7 every time. This confirms first-datum load and the final CAPTURE fold.
- wr_ready=0 for 3 cycles on window 5 → wr_en/wr_addr/wr_data stay stable and rd_en stays 0. Total run time grows by exactly 3 cycles.
- start pulsed during busy → ignored, and there is exactly one done. start held high through DONE → a second pass starts, with rd_addr=0 in the cycle after the IDLE cycle.
- rst_n=0 for one cycle during window 10's FETCH → all outputs are 0 on the next edge, with no done and no writes. A new start restarts from rd_addr 0 and wr_addr 0.
